// File: rtl/disp_hm_scan.sv
// ---------------------------------------------------------------------------
// disp_hm_scan
//   Drives a 4-digit multiplexed 7-segment display (HH:MM) from the BCD
//   outputs of the hour/minute counters. All four digits are captured into
//   shadow registers once per scan frame so a counter update mid-frame never
//   shows a torn value. Hour and minute pairs can blink independently for
//   time-setting, and the colon blinks at the same rate.
//
// Parameters
//   SCAN_DIV      clock cycles each digit stays lit (>= 2)
//   BLINK_FRAMES  full 4-digit frames per blink-phase toggle (>= 1)
//
// Ports
//   dsp_clock   in   system clock
//   dsp_reset   in   asynchronous active-low reset
//   dsp_enable  in   1 = scan runs, 0 = freeze counters and blank display
//   dsp_h_uni   in   hours units digit (4b)
//   dsp_h_dez   in   hours tens digit (3b)
//   dsp_m_uni   in   minutes units digit (4b)
//   dsp_m_dez   in   minutes tens digit (3b)
//   dsp_blink   in   bit1 = blink hour pair, bit0 = blink minute pair
//   dsp_seg     out  segments a..g on bit6..bit0, active-low
//   dsp_dp      out  colon point, active-low
//   dsp_an      out  digit anodes, active-low, one-hot or all off
//   dsp_frame   out  one-cycle pulse when a new snapshot takes effect
// ---------------------------------------------------------------------------
module disp_hm_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       dsp_clock,
    input  logic       dsp_reset,
    input  logic       dsp_enable,
    input  logic [3:0] dsp_h_uni,
    input  logic [2:0] dsp_h_dez,
    input  logic [3:0] dsp_m_uni,
    input  logic [2:0] dsp_m_dez,
    input  logic [1:0] dsp_blink,
    output logic [6:0] dsp_seg,
    output logic       dsp_dp,
    output logic [3:0] dsp_an,
    output logic       dsp_frame
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

    // Active-low abcdefg; anything outside 0..9 shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111110;
        endcase
        return s;
    endfunction

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] blk_q, blk_d;
    logic          phase_q, phase_d;
    logic [3:0]    sh_mu_q, sh_md_q, sh_hu_q, sh_hd_q;
    logic [3:0]    sh_mu_d, sh_md_d, sh_hu_d, sh_hd_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic          frame_q, frame_d;

    logic          tick;
    logic          snap;
    logic [3:0]    cur_digit;

    always_comb begin
        tick = (pre_q == PRE_LAST) && dsp_enable;
        snap = tick && (idx_q == 2'd3);

        // Prescaler and digit index freeze while disabled so a re-enable
        // resumes the same digit with its remaining dwell time.
        pre_d = pre_q;
        if (dsp_enable) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
        idx_d = tick ? idx_q + 2'd1 : idx_q;

        blk_d   = blk_q;
        phase_d = phase_q;
        sh_mu_d = sh_mu_q;
        sh_md_d = sh_md_q;
        sh_hu_d = sh_hu_q;
        sh_hd_d = sh_hd_q;
        if (snap) begin
            sh_mu_d = dsp_m_uni;
            sh_md_d = {1'b0, dsp_m_dez};
            sh_hu_d = dsp_h_uni;
            sh_hd_d = {1'b0, dsp_h_dez};
            if (blk_q == BLK_LAST) begin
                blk_d   = '0;
                phase_d = ~phase_q;
            end else begin
                blk_d = blk_q + 1'b1;
            end
        end

        case (idx_q)
            2'd0:    cur_digit = sh_mu_q;
            2'd1:    cur_digit = sh_md_q;
            2'd2:    cur_digit = sh_hu_q;
            default: cur_digit = sh_hd_q;
        endcase

        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (dsp_enable) begin
            // idx_q[1] selects the pair: 0 = minutes, 1 = hours.
            if (!(dsp_blink[idx_q[1]] && !phase_q)) begin
                an_d = ~(4'b0001 << idx_q);
            end
            // Segments stay driven on a blanked digit; the anode gates them.
            seg_d = seg_decode(cur_digit);
            dp_d  = !((idx_q == 2'd2) && phase_q);
        end
        frame_d = snap;
    end

    always_ff @(posedge dsp_clock or negedge dsp_reset) begin
        if (!dsp_reset) begin
            pre_q   <= '0;
            idx_q   <= 2'd0;
            blk_q   <= '0;
            phase_q <= 1'b1;
            sh_mu_q <= 4'd0;
            sh_md_q <= 4'd0;
            sh_hu_q <= 4'd0;
            sh_hd_q <= 4'd0;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
            an_q    <= 4'b1111;
            frame_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            blk_q   <= blk_d;
            phase_q <= phase_d;
            sh_mu_q <= sh_mu_d;
            sh_md_q <= sh_md_d;
            sh_hu_q <= sh_hu_d;
            sh_hd_q <= sh_hd_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign dsp_seg   = seg_q;
    assign dsp_dp    = dp_q;
    assign dsp_an    = an_q;
    assign dsp_frame = frame_q;

endmodule

// File: tb/tb_disp_hm_scan.sv
module tb_disp_hm_scan;

    localparam logic [6:0] D0   = 7'b0000001;
    localparam logic [6:0] D1   = 7'b1001111;
    localparam logic [6:0] D2   = 7'b0010010;
    localparam logic [6:0] D3   = 7'b0000110;
    localparam logic [6:0] D4   = 7'b1001100;
    localparam logic [6:0] D5   = 7'b0100100;
    localparam logic [6:0] D7   = 7'b0001111;
    localparam logic [6:0] D9   = 7'b0000100;
    localparam logic [6:0] DASH = 7'b1111110;
    localparam logic [6:0] OFF  = 7'b1111111;

    logic       dsp_clock;
    logic       dsp_reset;
    logic       dsp_enable;
    logic [3:0] dsp_h_uni;
    logic [2:0] dsp_h_dez;
    logic [3:0] dsp_m_uni;
    logic [2:0] dsp_m_dez;
    logic [1:0] dsp_blink;
    logic [6:0] dsp_seg;
    logic       dsp_dp;
    logic [3:0] dsp_an;
    logic       dsp_frame;

    int n_checks = 0;
    int n_errors = 0;

    disp_hm_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .dsp_clock (dsp_clock),
        .dsp_reset (dsp_reset),
        .dsp_enable(dsp_enable),
        .dsp_h_uni (dsp_h_uni),
        .dsp_h_dez (dsp_h_dez),
        .dsp_m_uni (dsp_m_uni),
        .dsp_m_dez (dsp_m_dez),
        .dsp_blink (dsp_blink),
        .dsp_seg   (dsp_seg),
        .dsp_dp    (dsp_dp),
        .dsp_an    (dsp_an),
        .dsp_frame (dsp_frame)
    );

    initial begin
        dsp_clock = 1'b0;
        forever #5 dsp_clock = ~dsp_clock;
    end

    typedef struct {
        logic [3:0] hu;
        logic [2:0] hd;
        logic [3:0] mu;
        logic [2:0] md;
        logic [1:0] blk;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    vec_t vecs [28];

    function automatic vec_t mk(input logic [3:0] hu, input logic [2:0] hd,
                                input logic [3:0] mu, input logic [2:0] md,
                                input logic [1:0] blk, input logic [3:0] an,
                                input logic [6:0] seg, input logic dp);
        vec_t v;
        v.hu = hu; v.hd = hd; v.mu = mu; v.md = md; v.blk = blk;
        v.an = an; v.seg = seg; v.dp = dp;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] an,
                              input logic [6:0] seg, input logic dp);
        check({tag, " an"},  {4'b0, dsp_an},  {4'b0, an});
        check({tag, " seg"}, {1'b0, dsp_seg}, {1'b0, seg});
        check({tag, " dp"},  {7'b0, dsp_dp},  {7'b0, dp});
    endtask

    // One digit slot = 4 clock edges. Called from a negedge, returns on the
    // negedge after the slot's last edge. Frame pulse is visible then only
    // for the idx3 slot, since the snapshot happens on its last edge.
    task automatic run_slot(input string tag, input logic [3:0] an,
                            input logic [6:0] seg, input logic dp, input logic frm);
        @(posedge dsp_clock);
        @(posedge dsp_clock);
        @(negedge dsp_clock);
        check_outs(tag, an, seg, dp);
        @(posedge dsp_clock);
        @(posedge dsp_clock);
        @(negedge dsp_clock);
        check({tag, " frame"}, {7'b0, dsp_frame}, {7'b0, frm});
    endtask

    initial begin
        // f0, phase 1: shadows still zero
        vecs[0]  = mk(4'd2, 3'd1, 4'd4, 3'd3, 2'b00, 4'b1110, D0, 1'b1);
        vecs[1]  = mk(4'd2, 3'd1, 4'd4, 3'd3, 2'b00, 4'b1101, D0, 1'b1);
        vecs[2]  = mk(4'd2, 3'd1, 4'd4, 3'd3, 2'b00, 4'b1011, D0, 1'b0);
        vecs[3]  = mk(4'd2, 3'd1, 4'd4, 3'd3, 2'b00, 4'b0111, D0, 1'b1);
        // f1, phase 1: shows 12:34, m_uni changes to 7 at idx1
        vecs[4]  = mk(4'd2, 3'd1, 4'd4, 3'd3, 2'b00, 4'b1110, D4, 1'b1);
        vecs[5]  = mk(4'd2, 3'd1, 4'd7, 3'd3, 2'b00, 4'b1101, D3, 1'b1);
        vecs[6]  = mk(4'd2, 3'd1, 4'd7, 3'd3, 2'b00, 4'b1011, D2, 1'b0);
        vecs[7]  = mk(4'd2, 3'd1, 4'd7, 3'd3, 2'b00, 4'b0111, D1, 1'b1);
        // f2, phase 0: hour blink, h_uni=12 pending capture
        vecs[8]  = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b10, 4'b1110, D7, 1'b1);
        vecs[9]  = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b10, 4'b1101, D3, 1'b1);
        vecs[10] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b10, 4'b1111, D2, 1'b1);
        vecs[11] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b10, 4'b1111, D1, 1'b1);
        // f3, phase 0: blink dropped for idx2 only to expose the dash
        vecs[12] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b10, 4'b1110, D7, 1'b1);
        vecs[13] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b10, 4'b1101, D3, 1'b1);
        vecs[14] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b00, 4'b1011, DASH, 1'b1);
        vecs[15] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b10, 4'b1111, D1, 1'b1);
        // f4, phase 1: hour blink set but visible phase
        vecs[16] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b10, 4'b1110, D7, 1'b1);
        vecs[17] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b10, 4'b1101, D3, 1'b1);
        vecs[18] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b10, 4'b1011, DASH, 1'b0);
        vecs[19] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b10, 4'b0111, D1, 1'b1);
        // f5, phase 1: minute blink, visible phase
        vecs[20] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b01, 4'b1110, D7, 1'b1);
        vecs[21] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b01, 4'b1101, D3, 1'b1);
        vecs[22] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b01, 4'b1011, DASH, 1'b0);
        vecs[23] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b01, 4'b0111, D1, 1'b1);
        // f6, phase 0: minute anodes off
        vecs[24] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b01, 4'b1111, D7, 1'b1);
        vecs[25] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b01, 4'b1111, D3, 1'b1);
        vecs[26] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b01, 4'b1011, DASH, 1'b1);
        vecs[27] = mk(4'd12, 3'd1, 4'd7, 3'd3, 2'b01, 4'b0111, D1, 1'b1);

        dsp_reset  = 1'b0;
        dsp_enable = 1'b1;
        dsp_h_uni  = 4'd2;
        dsp_h_dez  = 3'd1;
        dsp_m_uni  = 4'd4;
        dsp_m_dez  = 3'd3;
        dsp_blink  = 2'b00;

        repeat (3) @(posedge dsp_clock);
        @(negedge dsp_clock);
        check_outs("reset", 4'b1111, OFF, 1'b1);
        check("reset frame", {7'b0, dsp_frame}, 8'd0);
        dsp_reset = 1'b1;

        for (int i = 0; i < 28; i++) begin
            dsp_h_uni = vecs[i].hu;
            dsp_h_dez = vecs[i].hd;
            dsp_m_uni = vecs[i].mu;
            dsp_m_dez = vecs[i].md;
            dsp_blink = vecs[i].blk;
            run_slot($sformatf("slot%0d", i), vecs[i].an, vecs[i].seg, vecs[i].dp, (i % 4) == 3);
        end

        // f7 (phase 0), idx0: disable mid-digit with 2 of 4 counts used
        dsp_blink = 2'b00;
        @(posedge dsp_clock);
        @(posedge dsp_clock);
        @(negedge dsp_clock);
        check_outs("pre-disable", 4'b1110, D7, 1'b1);
        dsp_enable = 1'b0;
        @(negedge dsp_clock);
        check_outs("disable first", 4'b1111, OFF, 1'b1);
        repeat (9) @(negedge dsp_clock);
        check_outs("disable end", 4'b1111, OFF, 1'b1);
        check("disable frame", {7'b0, dsp_frame}, 8'd0);
        dsp_enable = 1'b1;
        @(negedge dsp_clock);
        check_outs("resume a", 4'b1110, D7, 1'b1);
        @(negedge dsp_clock);
        check_outs("resume b", 4'b1110, D7, 1'b1);
        @(negedge dsp_clock);
        check_outs("resume c", 4'b1101, D3, 1'b1);

        // Asynchronous reset between clock edges
        #2;
        dsp_reset = 1'b0;
        #1;
        check_outs("async reset", 4'b1111, OFF, 1'b1);
        check("async reset frame", {7'b0, dsp_frame}, 8'd0);
        dsp_h_uni = 4'd3;
        dsp_h_dez = 3'd2;
        dsp_m_uni = 4'd9;
        dsp_m_dez = 3'd5;
        repeat (2) @(negedge dsp_clock);
        dsp_reset = 1'b1;

        run_slot("post-rst s0", 4'b1110, D0, 1'b1, 1'b0);
        run_slot("post-rst s1", 4'b1101, D0, 1'b1, 1'b0);
        run_slot("post-rst s2", 4'b1011, D0, 1'b0, 1'b0);
        run_slot("post-rst s3", 4'b0111, D0, 1'b1, 1'b1);
        run_slot("post-rst s4", 4'b1110, D9, 1'b1, 1'b0);
        run_slot("post-rst s5", 4'b1101, D5, 1'b1, 1'b0);
        run_slot("post-rst s6", 4'b1011, D3, 1'b0, 1'b0);
        run_slot("post-rst s7", 4'b0111, D2, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
